// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, the instruction register and the
// fetch handshake with instruction memory. A fetch requested in IDLE either
// completes in the same cycle (zero-wait) or parks the unit in WAIT, stalling
// the control FSM until memory returns data.
//
// Optional build macro: FETCH_TIMEOUT_EN
//   When defined, a WAIT lasting TIMEOUT_CYCLES cycles without a response
//   aborts the fetch: a NOP is loaded and o_FetchFault pulses for one cycle.
//   When undefined, WAIT lasts until data arrives and o_FetchFault is 0.
//
// Ports:
//   i_Clk         clock, rising edge
//   i_Reset       synchronous active-low reset
//   i_PCUpdate    unconditional PC write request
//   i_Branch      conditional branch request (taken when i_Zero)
//   i_Zero        ALU zero flag
//   i_IRWrite     instruction fetch request
//   i_Result      next-PC value (word aligned on write)
//   i_MemRData    instruction memory read data
//   i_MemRValid   i_MemRData valid this cycle
//   o_PC          current PC / fetch address
//   o_OldPC       PC of the instruction held in o_Instr
//   o_Instr       instruction register
//   o_OpCode      o_Instr[6:0], combinational
//   o_MemReq      fetch request to memory, combinational
//   o_Stall       control FSM hold, combinational
//   o_FetchFault  one-cycle fetch timeout pulse, combinational
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_PCUpdate,
   input  logic        i_Branch,
   input  logic        i_Zero,
   input  logic        i_IRWrite,
   input  logic [31:0] i_Result,
   input  logic [31:0] i_MemRData,
   input  logic        i_MemRValid,
   output logic [31:0] o_PC,
   output logic [31:0] o_OldPC,
   output logic [31:0] o_Instr,
   output logic [6:0]  o_OpCode,
   output logic        o_MemReq,
   output logic        o_Stall,
   output logic        o_FetchFault
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // The timeout counter is 5 bits wide, so the limit must fit in it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
      $error("instr_fetch_unit: TIMEOUT_CYCLES must be in 1..32");
   end

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t state;
   logic   idle_fetch;
   logic   wait_st;
   logic   timeout_hit;
   logic   pc_write;

   assign idle_fetch = (state == S_IDLE) & i_IRWrite;
   assign wait_st    = (state == S_WAIT);

`ifdef FETCH_TIMEOUT_EN
   localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

   logic [4:0] wait_cnt;

   // Last permitted WAIT cycle passed with no response: abort the fetch.
   assign timeout_hit = wait_st & ~i_MemRValid & (wait_cnt == TIMEOUT_LAST);

   // Counts cycles spent in WAIT; cleared whenever the unit is not staying there.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         wait_cnt <= 5'd0;
      end else if (wait_st & ~i_MemRValid & ~timeout_hit) begin
         wait_cnt <= wait_cnt + 5'd1;
      end else begin
         wait_cnt <= 5'd0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Handshake outputs are forced low while reset is asserted.
   assign o_MemReq     = i_Reset & (idle_fetch | wait_st);
   assign o_Stall      = i_Reset & ~i_MemRValid & (idle_fetch | (wait_st & ~timeout_hit));
   assign o_FetchFault = i_Reset & timeout_hit;
   assign o_OpCode     = o_Instr[6:0];

   assign pc_write = (i_PCUpdate | (i_Branch & i_Zero)) & ~o_Stall;

   // Fetch state, PC and instruction register. o_OldPC always samples the
   // pre-update PC, so a capture and a PC write on the same edge are consistent.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         state   <= S_IDLE;
         o_PC    <= RESET_PC;
         o_OldPC <= RESET_PC;
         o_Instr <= NOP_INSTR;
      end else begin
         if (pc_write) begin
            o_PC <= {i_Result[31:2], 2'b00};
         end
         case (state)
            S_IDLE: begin
               if (i_IRWrite) begin
                  if (i_MemRValid) begin
                     o_Instr <= i_MemRData;
                     o_OldPC <= o_PC;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (i_MemRValid) begin
                  o_Instr <= i_MemRData;
                  o_OldPC <= o_PC;
                  state   <= S_IDLE;
               end else if (timeout_hit) begin
                  o_Instr <= NOP_INSTR;
                  o_OldPC <= o_PC;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: each directed step pushes its
// hand-computed expectations; a monitor pops them and checks the
// combinational outputs before the edge and the registers after it.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pcu, br, zero, irw, rv;
   logic [31:0] res, rdata;
   logic [31:0] pc, old_pc, instr;
   logic [6:0]  opcode;
   logic        mem_req, stall, fault;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic        stall;
      logic        mem_req;
      logic        fault;
      logic [31:0] pc;
      logic [31:0] old_pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
      .i_Clk(clk), .i_Reset(rst_n), .i_PCUpdate(pcu), .i_Branch(br),
      .i_Zero(zero), .i_IRWrite(irw), .i_Result(res), .i_MemRData(rdata),
      .i_MemRValid(rv), .o_PC(pc), .o_OldPC(old_pc), .o_Instr(instr),
      .o_OpCode(opcode), .o_MemReq(mem_req), .o_Stall(stall),
      .o_FetchFault(fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT should do with them.
   task automatic step(input string name, input logic r, input logic p, input logic b,
                       input logic z, input logic i, input logic [31:0] rs,
                       input logic [31:0] rd, input logic v,
                       input logic e_stall, input logic e_req, input logic e_fault,
                       input logic [31:0] e_pc, input logic [31:0] e_old,
                       input logic [31:0] e_instr);
      exp_t e;
      rst_n = r; pcu = p; br = b; zero = z; irw = i; res = rs; rdata = rd; rv = v;
      e.name = name; e.stall = e_stall; e.mem_req = e_req; e.fault = e_fault;
      e.pc = e_pc; e.old_pc = e_old; e.instr = e_instr;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: combinational outputs mid-cycle, registers just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".stall"},   32'(stall),   32'(e.stall));
            chk({e.name, ".mem_req"}, 32'(mem_req), 32'(e.mem_req));
            chk({e.name, ".fault"},   32'(fault),   32'(e.fault));
            @(posedge clk);
            #1;
            chk({e.name, ".pc"},     pc,     e.pc);
            chk({e.name, ".old_pc"}, old_pc, e.old_pc);
            chk({e.name, ".instr"},  instr,  e.instr);
            chk({e.name, ".opcode"}, 32'(opcode), 32'(e.instr[6:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; pcu = 0; br = 0; zero = 0; irw = 0; rv = 0; res = '0; rdata = '0;
      @(posedge clk);
      #2;
      //    name          rst p b z i  result        rdata         v  stl req flt pc            old           instr
      step("reset",       0, 0,0,0,1, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h13);
      step("zw_fetch",    1, 1,0,0,1, 32'h4,        32'h2003,     1, 0, 1, 0, 32'h4,        32'h0,        32'h2003);
      for (int k = 0; k < 3; k++)
         step("stall",    1, 1,0,0,1, 32'h8,        32'h0,        0, 1, 1, 0, 32'h4,        32'h0,        32'h2003);
      step("wait_done",   1, 1,0,0,1, 32'h8,        32'h0040_0093,1, 0, 1, 0, 32'h8,        32'h4,        32'h0040_0093);
      step("idle_rvalid", 1, 0,0,0,0, 32'h100,      32'hdead_beef,1, 0, 0, 0, 32'h8,        32'h4,        32'h0040_0093);
      step("br_not_tkn",  1, 0,1,0,0, 32'h40,       32'h0,        0, 0, 0, 0, 32'h8,        32'h4,        32'h0040_0093);
      step("br_taken",    1, 0,1,1,0, 32'h40,       32'h0,        0, 0, 0, 0, 32'h40,       32'h4,        32'h0040_0093);
      step("br_align43",  1, 0,1,1,0, 32'h43,       32'h0,        0, 0, 0, 0, 32'h40,       32'h4,        32'h0040_0093);
      step("br_align47",  1, 0,1,1,0, 32'h47,       32'h0,        0, 0, 0, 0, 32'h44,       32'h4,        32'h0040_0093);
      step("enter_wait",  1, 0,0,0,1, 32'h0,        32'h0,        0, 1, 1, 0, 32'h44,       32'h4,        32'h0040_0093);
      step("rst_in_wait", 0, 1,0,0,1, 32'h80,       32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h13);
      step("late_data",   1, 0,0,0,0, 32'h0,        32'h0000_0bad,1, 0, 0, 0, 32'h0,        32'h0,        32'h13);
      step("zw_branch",   1, 0,1,1,1, 32'h20,       32'h63,       1, 0, 1, 0, 32'h20,       32'h0,        32'h63);
      // Long wait: request cycle plus 15 WAIT cycles all stall in either build.
      for (int k = 0; k < 16; k++)
         step("long_wait",1, 0,0,0,1, 32'h0,        32'h0,        0, 1, 1, 0, 32'h20,       32'h0,        32'h63);
`ifdef FETCH_TIMEOUT_EN
      step("timeout",     1, 0,0,0,1, 32'h0,        32'h0,        0, 0, 1, 1, 32'h20,       32'h20,       32'h13);
      step("after_to",    1, 0,0,0,0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h20,       32'h20,       32'h13);
`else
      for (int k = 0; k < 4; k++)
         step("no_timeout",1,0,0,0,1, 32'h0,        32'h0,        0, 1, 1, 0, 32'h20,       32'h0,        32'h63);
      step("late_done",   1, 0,0,0,0, 32'h0,        32'h0010_0073,1, 0, 1, 0, 32'h20,       32'h20,       32'h0010_0073);
      step("after_done",  1, 0,0,0,0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h20,       32'h20,       32'h0010_0073);
`endif
      rv = 0; irw = 0; pcu = 0; br = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, WAIT cycles before fetch fault (used only with FETCH_TIMEOUT_EN).
REQ-003 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_Reset  input  1  synchronous, active-low reset.
REQ-005 i_PCUpdate  input  1  unconditional PC write request from control FSM.
REQ-006 i_Branch  input  1  conditional branch request from control FSM.
REQ-007 i_Zero  input  1  ALU zero flag.
REQ-008 i_IRWrite  input  1  instruction fetch request (FETCH state).
REQ-009 i_Result  input  32  next-PC value from result mux.
REQ-010 i_MemRData  input  32  instruction memory read data.
REQ-011 i_MemRValid  input  1  i_MemRData valid this cycle.
REQ-012 o_PC  output  32  current PC; also memory fetch address.
REQ-013 o_OldPC  output  32  PC of the instruction held in o_Instr.
REQ-014 o_Instr  output  32  instruction register.
REQ-015 o_OpCode  output  7  o_Instr[6:0], to control FSM.
REQ-016 o_MemReq  output  1  fetch request to instruction memory.
REQ-017 o_Stall  output  1  combinational; control FSM holds state and outputs while high.
REQ-018 o_FetchFault  output  1  one-cycle pulse on fetch timeout (FETCH_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-019 States: IDLE, WAIT.
REQ-020 PCWrite = i_PCUpdate | (i_Branch & i_Zero), gated by ~o_Stall.
REQ-021 On PCWrite, o_PC <= {i_Result[31:2], 2'b00} next edge; low bits always zero.
REQ-022 o_MemReq = (IDLE & i_IRWrite) | WAIT.
REQ-023 o_Stall = (IDLE & i_IRWrite & ~i_MemRValid) | (WAIT & ~i_MemRValid).
REQ-024 IDLE & i_IRWrite & i_MemRValid: zero-wait fetch; o_Instr <= i_MemRData, o_OldPC <= o_PC, stay IDLE.
REQ-025 IDLE & i_IRWrite & ~i_MemRValid: go WAIT; o_Instr, o_OldPC unchanged.
REQ-026 WAIT & i_MemRValid: o_Instr <= i_MemRData, o_OldPC <= o_PC, PCWrite permitted same edge, go IDLE.
REQ-027 WAIT & ~i_MemRValid: stay WAIT; o_PC, o_OldPC, o_Instr held.
REQ-028 i_MemRValid in IDLE without i_IRWrite ignored; no register change.
REQ-029 Simultaneous capture and PCWrite: o_OldPC takes pre-update o_PC; o_PC takes new value.
REQ-030 PCWrite in IDLE without i_IRWrite (branch/JAL) updates o_PC only.
REQ-031 o_OpCode combinational from o_Instr; no added latency.

Reset
REQ-032 i_Reset low at edge: state IDLE, o_PC = RESET_PC, o_OldPC = RESET_PC, o_Instr = 32'h0000_0013 (NOP), timeout counter 0.
REQ-033 Reset dominates all other inputs, including mid-WAIT; pending response discarded.
REQ-034 During reset cycle o_Stall, o_MemReq, o_FetchFault = 0.

Configuration
REQ-035 Macro FETCH_TIMEOUT_EN: when defined, 5-bit counter increments each WAIT cycle, clears on leaving WAIT.
REQ-036 With FETCH_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES-1 in WAIT without i_MemRValid: o_Instr <= NOP, o_OldPC <= o_PC, o_FetchFault pulses, go IDLE, o_Stall low that cycle.
REQ-037 Without FETCH_TIMEOUT_EN: no counter, WAIT indefinite, o_FetchFault constant 0.

Verification
REQ-038 Reset low one cycle, RESET_PC=0 -> o_PC=0, o_Instr=32'h13, o_OpCode=7'h13, o_Stall=0.
REQ-039 o_PC=0, IRWrite+PCUpdate+RValid, RData=32'h0000_2003, Result=4 -> next: o_Instr=32'h2003, o_OldPC=0, o_PC=4, no stall.
REQ-040 IRWrite+PCUpdate, RValid low 3 cycles then high, Result=8 -> o_Stall high 3 cycles, o_PC held at 4, then o_PC=8, o_OldPC=4.
REQ-041 Branch=1, Zero=0, Result=32'h40 -> o_PC unchanged; Zero=1 -> o_PC=32'h40; Result=32'h43 -> o_PC=32'h40.
REQ-042 Reset asserted in WAIT, RValid arrives after -> IDLE, o_PC=RESET_PC, o_Instr=NOP, late data ignored.
REQ-043 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, RValid never -> o_FetchFault pulse on 16th WAIT cycle, o_Instr=NOP, state IDLE.
